bsg_manycore_eva_xlate_arbiter: RTL and testbench

Shares one combinational EVA-to-NPA translator between num_req_p requesters (e.g. LSU, icache refill, DMA), round-robin.
Owns the tile-group configuration registers (origin, dimension, DRAM mode) and drives them into the translator.
Pipelines each translation through an EVA stage (S0) and a result stage (S1), and tags every result with its requester id.
Sits between endpoint request sources and the network-packet formation logic.

---
 rtl/bsg_manycore_eva_xlate_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_bsg_manycore_eva_xlate_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_eva_xlate_arbiter.sv
// Round-robin arbiter sharing one EVA->NPA translator, with a two-stage (EVA, result) pipeline and tile-group config registers.
// Optional build macro BSG_MANYCORE_EVA_XLATE_DROP_INVALID_EN: drop invalid translations and capture the first bad EVA on err_eva_o.
module bsg_manycore_eva_xlate_arbiter #(
  parameter int num_req_p      = 2,
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 28,
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7,
  parameter int cnt_width_p    = 16,
  localparam int id_w          = $clog2(num_req_p)
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              cfg_v_i,
  input  logic [x_cord_width_p-1:0]         cfg_tgo_x_i,
  input  logic [y_cord_width_p-1:0]         cfg_tgo_y_i,
  input  logic [x_cord_width_p-1:0]         cfg_tg_dim_x_i,
  input  logic [y_cord_width_p-1:0]         cfg_tg_dim_y_i,
  input  logic                              cfg_dram_enable_i,
  output logic                              cfg_ready_o,
  input  logic [num_req_p-1:0]              req_v_i,
  input  logic [num_req_p*data_width_p-1:0] req_eva_i,
  output logic [num_req_p-1:0]              req_ready_o,
  output logic [data_width_p-1:0]           xl_eva_o,
  output logic [x_cord_width_p-1:0]         xl_tgo_x_o,
  output logic [y_cord_width_p-1:0]         xl_tgo_y_o,
  output logic [x_cord_width_p-1:0]         xl_tg_dim_x_o,
  output logic [y_cord_width_p-1:0]         xl_tg_dim_y_o,
  output logic                              xl_dram_enable_o,
  input  logic [x_cord_width_p-1:0]         xl_x_cord_i,
  input  logic [y_cord_width_p-1:0]         xl_y_cord_i,
  input  logic [addr_width_p-1:0]           xl_epa_i,
  input  logic                              xl_invalid_i,
  output logic                              v_o,
  output logic [x_cord_width_p-1:0]         x_cord_o,
  output logic [y_cord_width_p-1:0]         y_cord_o,
  output logic [addr_width_p-1:0]           epa_o,
  output logic                              invalid_o,
  output logic [id_w-1:0]                   req_id_o,
  input  logic                              yumi_i,
  output logic [cnt_width_p-1:0]            invalid_count_o
`ifdef BSG_MANYCORE_EVA_XLATE_DROP_INVALID_EN
  , output logic [data_width_p-1:0]         err_eva_o
`endif
);

  logic [data_width_p-1:0] eva_arr [num_req_p];

  genvar gi;
  generate
    for (gi = 0; gi < num_req_p; gi++) begin : g_unpack
      assign eva_arr[gi] = req_eva_i[gi*data_width_p +: data_width_p];
    end
  endgenerate

  logic                      s0_v_reg;
  logic [data_width_p-1:0]   s0_eva_reg;
  logic [id_w-1:0]           s0_id_reg;
  logic                      s1_v_reg;
  logic [x_cord_width_p-1:0] s1_x_reg;
  logic [y_cord_width_p-1:0] s1_y_reg;
  logic [addr_width_p-1:0]   s1_epa_reg;
  logic                      s1_invalid_reg;
  logic [id_w-1:0]           s1_id_reg;
  logic [id_w-1:0]           rr_ptr_reg;
  logic [cnt_width_p-1:0]    invalid_count_reg;
  logic [x_cord_width_p-1:0] tgo_x_reg, tg_dim_x_reg;
  logic [y_cord_width_p-1:0] tgo_y_reg, tg_dim_y_reg;
  logic                      dram_enable_reg;

  logic            s0_move, s1_load, s0_open, grant_en;
  logic            grant_found;
  logic [id_w-1:0] grant_id;
  logic [id_w:0]   arb_idx;
  logic [id_w-1:0] rr_ptr_next;

  // Search starts at the pointer and wraps; arb_idx stays below num_req_p after the wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    arb_idx     = '0;
    for (int i = 0; i < num_req_p; i++) begin
      arb_idx = {1'b0, rr_ptr_reg} + (id_w+1)'(i);
      if (arb_idx >= (id_w+1)'(num_req_p))
        arb_idx = arb_idx - (id_w+1)'(num_req_p);
      if (!grant_found && req_v_i[arb_idx[id_w-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = arb_idx[id_w-1:0];
      end
    end
  end

`ifdef BSG_MANYCORE_EVA_XLATE_DROP_INVALID_EN
  // A dropped translation never needs S1, so it leaves S0 even when S1 is stalled.
  assign s0_move = s0_v_reg & (~s1_v_reg | yumi_i | xl_invalid_i);
  assign s1_load = s0_move & ~xl_invalid_i;
`else
  assign s0_move = s0_v_reg & (~s1_v_reg | yumi_i);
  assign s1_load = s0_move;
`endif

  assign s0_open     = ~s0_v_reg | s0_move;
  // Any pending config write freezes new grants so the pipeline drains under it.
  assign grant_en    = s0_open & ~cfg_v_i & grant_found;
  assign cfg_ready_o = cfg_v_i & ~s0_v_reg & ~s1_v_reg;
  assign rr_ptr_next = (grant_id == id_w'(num_req_p-1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    req_ready_o = '0;
    if (grant_en)
      req_ready_o[grant_id] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s0_v_reg          <= 1'b0;
      s0_eva_reg        <= '0;
      s0_id_reg         <= '0;
      s1_v_reg          <= 1'b0;
      s1_x_reg          <= '0;
      s1_y_reg          <= '0;
      s1_epa_reg        <= '0;
      s1_invalid_reg    <= 1'b0;
      s1_id_reg         <= '0;
      rr_ptr_reg        <= '0;
      invalid_count_reg <= '0;
      tgo_x_reg         <= '0;
      tgo_y_reg         <= '0;
      tg_dim_x_reg      <= '0;
      tg_dim_y_reg      <= '0;
      dram_enable_reg   <= 1'b0;
    end else begin
      if (grant_en) begin
        s0_v_reg   <= 1'b1;
        s0_eva_reg <= eva_arr[grant_id];
        s0_id_reg  <= grant_id;
        rr_ptr_reg <= rr_ptr_next;
      end else if (s0_move) begin
        s0_v_reg <= 1'b0;
      end

      if (s1_load) begin
        s1_v_reg       <= 1'b1;
        s1_x_reg       <= xl_x_cord_i;
        s1_y_reg       <= xl_y_cord_i;
        s1_epa_reg     <= xl_epa_i;
        s1_invalid_reg <= xl_invalid_i;
        s1_id_reg      <= s0_id_reg;
      end else if (yumi_i) begin
        s1_v_reg <= 1'b0;
      end

      if (s0_move && xl_invalid_i && (invalid_count_reg != '1))
        invalid_count_reg <= invalid_count_reg + 1'b1;

      if (cfg_ready_o) begin
        tgo_x_reg       <= cfg_tgo_x_i;
        tgo_y_reg       <= cfg_tgo_y_i;
        tg_dim_x_reg    <= cfg_tg_dim_x_i;
        tg_dim_y_reg    <= cfg_tg_dim_y_i;
        dram_enable_reg <= cfg_dram_enable_i;
      end
    end
  end

`ifdef BSG_MANYCORE_EVA_XLATE_DROP_INVALID_EN
  logic                    err_v_reg;
  logic [data_width_p-1:0] err_eva_reg;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_v_reg   <= 1'b0;
      err_eva_reg <= '0;
    end else if (s0_move && xl_invalid_i && !err_v_reg) begin
      err_v_reg   <= 1'b1;
      err_eva_reg <= s0_eva_reg;
    end
  end

  assign err_eva_o = err_eva_reg;
  assign invalid_o = 1'b0;
`else
  assign invalid_o = s1_invalid_reg;
`endif

  assign xl_eva_o         = s0_eva_reg;
  assign xl_tgo_x_o       = tgo_x_reg;
  assign xl_tgo_y_o       = tgo_y_reg;
  assign xl_tg_dim_x_o    = tg_dim_x_reg;
  assign xl_tg_dim_y_o    = tg_dim_y_reg;
  assign xl_dram_enable_o = dram_enable_reg;
  assign v_o              = s1_v_reg;
  assign x_cord_o         = s1_x_reg;
  assign y_cord_o         = s1_y_reg;
  assign epa_o            = s1_epa_reg;
  assign req_id_o         = s1_id_reg;
  assign invalid_count_o  = invalid_count_reg;

endmodule

// File: tb/tb_bsg_manycore_eva_xlate_arbiter.sv
// Randomized bench for bsg_manycore_eva_xlate_arbiter: scoreboard queue of granted EVAs, abstract
// round-robin / occupancy rules, and a toy translator driven from the DUT's xl_* outputs.
module tb_bsg_manycore_eva_xlate_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        cfg_v_i;
  logic [6:0]  cfg_tgo_x_i, cfg_tg_dim_x_i;
  logic [6:0]  cfg_tgo_y_i, cfg_tg_dim_y_i;
  logic        cfg_dram_enable_i;
  logic        cfg_ready_o;
  logic [1:0]  req_v_i;
  logic [63:0] req_eva_i;
  logic [1:0]  req_ready_o;
  logic [31:0] xl_eva_o;
  logic [6:0]  xl_tgo_x_o, xl_tgo_y_o, xl_tg_dim_x_o, xl_tg_dim_y_o;
  logic        xl_dram_enable_o;
  logic [6:0]  xl_x_cord_i, xl_y_cord_i;
  logic [27:0] xl_epa_i;
  logic        xl_invalid_i;
  logic        v_o;
  logic [6:0]  x_cord_o, y_cord_o;
  logic [27:0] epa_o;
  logic        invalid_o;
  logic [0:0]  req_id_o;
  logic        yumi_i;
  logic [3:0]  invalid_count_o;

  always #5 clk_i = ~clk_i;

  bsg_manycore_eva_xlate_arbiter #(
    .num_req_p(2), .data_width_p(32), .addr_width_p(28),
    .x_cord_width_p(7), .y_cord_width_p(7), .cnt_width_p(4)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .cfg_v_i(cfg_v_i), .cfg_tgo_x_i(cfg_tgo_x_i), .cfg_tgo_y_i(cfg_tgo_y_i),
    .cfg_tg_dim_x_i(cfg_tg_dim_x_i), .cfg_tg_dim_y_i(cfg_tg_dim_y_i),
    .cfg_dram_enable_i(cfg_dram_enable_i), .cfg_ready_o(cfg_ready_o),
    .req_v_i(req_v_i), .req_eva_i(req_eva_i), .req_ready_o(req_ready_o),
    .xl_eva_o(xl_eva_o), .xl_tgo_x_o(xl_tgo_x_o), .xl_tgo_y_o(xl_tgo_y_o),
    .xl_tg_dim_x_o(xl_tg_dim_x_o), .xl_tg_dim_y_o(xl_tg_dim_y_o),
    .xl_dram_enable_o(xl_dram_enable_o),
    .xl_x_cord_i(xl_x_cord_i), .xl_y_cord_i(xl_y_cord_i), .xl_epa_i(xl_epa_i),
    .xl_invalid_i(xl_invalid_i),
    .v_o(v_o), .x_cord_o(x_cord_o), .y_cord_o(y_cord_o), .epa_o(epa_o),
    .invalid_o(invalid_o), .req_id_o(req_id_o), .yumi_i(yumi_i),
    .invalid_count_o(invalid_count_o)
  );

  // Toy translator: the bench's own address map.
  typedef struct packed {
    logic [6:0]  x;
    logic [6:0]  y;
    logic [27:0] epa;
    logic        inv;
  } xl_t;

  function automatic xl_t xlate(input logic [31:0] eva, input logic [6:0] tx, input logic [6:0] ty);
    xl_t r;
    r.x   = eva[6:0] + tx;
    r.y   = eva[13:7] + ty;
    r.epa = eva[29:2];
    r.inv = eva[31];
    return r;
  endfunction

  xl_t xl_now;
  assign xl_now       = xlate(xl_eva_o, xl_tgo_x_o, xl_tgo_y_o);
  assign xl_x_cord_i  = xl_now.x;
  assign xl_y_cord_i  = xl_now.y;
  assign xl_epa_i     = xl_now.epa;
  assign xl_invalid_i = xl_now.inv;

  // Reference model: in-order list of granted EVAs with their age in clock edges.
  typedef struct {
    int          id;
    logic [31:0] eva;
    int          age;
    bit          entered;
  } item_t;

  item_t       q[$];
  int          m_ptr;
  int          m_cnt;
  logic [6:0]  m_tgo_x, m_tgo_y, m_dim_x, m_dim_y;
  logic        m_dram;
  logic [31:0] eva_cur [2];
  bit          granted [2];
  bit          force_inv;
  bit          cfg_taken;
  int          passed, total, failed;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] new_eva();
    logic [31:0] r;
    r = $urandom;
    r[31] = force_inv || ($urandom_range(0, 3) == 0);
    return r;
  endfunction

  function automatic bit model_v();
    return (q.size() > 0) && (q[0].age >= 2);
  endfunction

  task automatic model_reset();
    q.delete();
    m_ptr = 0; m_cnt = 0;
    m_tgo_x = '0; m_tgo_y = '0; m_dim_x = '0; m_dim_y = '0; m_dram = 1'b0;
  endtask

  task automatic drive(input logic [1:0] v, input bit y_en, input bit cfg);
    req_v_i   = v;
    req_eva_i = {eva_cur[1], eva_cur[0]};
    cfg_v_i   = cfg;
    yumi_i    = y_en && model_v();
  endtask

  // One clock cycle: check the DUT against the model, then advance the model across the edge.
  task automatic cycle();
    bit         exp_v, gv, exp_cfg;
    int         gid;
    logic [1:0] exp_rdy;
    xl_t        e;
    item_t      it;
    #1;
    exp_v = model_v();
    chk("v_o", 64'(v_o), 64'(exp_v));
    if (exp_v) begin
      e = xlate(q[0].eva, m_tgo_x, m_tgo_y);
      chk("x_cord", 64'(x_cord_o), 64'(e.x));
      chk("y_cord", 64'(y_cord_o), 64'(e.y));
      chk("epa", 64'(epa_o), 64'(e.epa));
      chk("invalid", 64'(invalid_o), 64'(e.inv));
      chk("req_id", 64'(req_id_o), 64'(q[0].id));
    end
    exp_cfg = cfg_v_i && (q.size() == 0);
    gv = 0; gid = 0;
    if (!cfg_v_i && (q.size() < 2 || yumi_i)) begin
      for (int k = 0; k < 2; k++) begin
        int c;
        c = (m_ptr + k) % 2;
        if (!gv && req_v_i[c]) begin gv = 1; gid = c; end
      end
    end
    exp_rdy = gv ? (2'b01 << gid) : 2'b00;
    chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));
    chk("cfg_ready", 64'(cfg_ready_o), 64'(exp_cfg));
    chk("inv_count", 64'(invalid_count_o), 64'(m_cnt));
    chk("tgo_x", 64'(xl_tgo_x_o), 64'(m_tgo_x));
    chk("tgo_y", 64'(xl_tgo_y_o), 64'(m_tgo_y));
    chk("dim", 64'({xl_tg_dim_x_o, xl_tg_dim_y_o, xl_dram_enable_o}), 64'({m_dim_x, m_dim_y, m_dram}));
    $display("t=%0t req_v=%b rdy=%b cfg=%b v=%b yumi=%b id=%0d cnt=%0d", $time,
             req_v_i, req_ready_o, cfg_v_i, v_o, yumi_i, req_id_o, invalid_count_o);
    @(posedge clk_i);
    if (yumi_i) void'(q.pop_front());
    foreach (q[k]) q[k].age++;
    if (gv) begin
      it.id = gid; it.eva = eva_cur[gid]; it.age = 1; it.entered = 0;
      q.push_back(it);
      m_ptr = (gid + 1) % 2;
      granted[gid] = 1;
    end
    if (exp_cfg) begin
      m_tgo_x = cfg_tgo_x_i; m_tgo_y = cfg_tgo_y_i;
      m_dim_x = cfg_tg_dim_x_i; m_dim_y = cfg_tg_dim_y_i; m_dram = cfg_dram_enable_i;
      cfg_taken = 1;
    end
    if (q.size() > 0 && q[0].age >= 2 && !q[0].entered) begin
      q[0].entered = 1;
      if (q[0].eva[31] && m_cnt < 15) m_cnt++;
    end
    @(negedge clk_i);
    for (int k = 0; k < 2; k++)
      if (granted[k]) begin granted[k] = 0; eva_cur[k] = new_eva(); end
  endtask

  initial begin
    passed = 0; total = 0; failed = 0;
    force_inv = 0; cfg_taken = 0;
    granted[0] = 0; granted[1] = 0;
    reset_n_i = 1'b0;
    cfg_v_i = 0; cfg_tgo_x_i = '0; cfg_tgo_y_i = '0;
    cfg_tg_dim_x_i = '0; cfg_tg_dim_y_i = '0; cfg_dram_enable_i = 0;
    req_v_i = '0; req_eva_i = '0; yumi_i = 0;
    eva_cur[0] = 32'h2000_0010;
    eva_cur[1] = new_eva();
    model_reset();
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;

    // Reset state, then a single request from requester 0 (grant then result two cycles later).
    drive(2'b00, 1, 0); cycle();
    drive(2'b01, 1, 0); cycle();
    repeat (4) begin drive(2'b00, 1, 0); cycle(); end

    // Both requesters continuously valid with the consumer always ready: alternating grants.
    repeat (12) begin drive(2'b11, 1, 0); cycle(); end

    // Consumer stalls for five cycles, then resumes; nothing is lost.
    repeat (5) begin drive(2'b11, 0, 0); cycle(); end
    repeat (6) begin drive(2'b11, 1, 0); cycle(); end

    // Random traffic with random back-pressure.
    repeat (300) begin drive(2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 0); cycle(); end

    // Config write while results are in flight: grants block until the pipeline drains.
    repeat (3) begin drive(2'b11, 0, 0); cycle(); end
    cfg_tgo_x_i = 7'd3; cfg_tgo_y_i = 7'd4;
    cfg_tg_dim_x_i = 7'd5; cfg_tg_dim_y_i = 7'd6; cfg_dram_enable_i = 1'b1;
    cfg_taken = 0;
    for (int n = 0; n < 20 && !cfg_taken; n++) begin drive(2'b11, 1, 1); cycle(); end
    chk("cfg_accepted", 64'(cfg_taken), 64'd1);
    drive(2'b11, 1, 0);
    #1;
    chk("tgo_x_after_cfg", 64'(xl_tgo_x_o), 64'd3);
    chk("tgo_y_after_cfg", 64'(xl_tgo_y_o), 64'd4);
    cycle();
    repeat (20) begin drive(2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 0); cycle(); end

    // Every translation invalid: the counter reaches all-ones and stays there.
    force_inv = 1;
    repeat (40) begin drive(2'b11, 1, 0); cycle(); end
    chk("inv_saturated", 64'(invalid_count_o), 64'd15);
    force_inv = 0;

    // Fill both stages, then assert reset between clock edges.
    repeat (4) begin drive(2'b11, 0, 0); cycle(); end
    drive(2'b11, 0, 0);
    @(posedge clk_i);
    #2 reset_n_i = 1'b0;
    #1;
    chk("rst_v_o", 64'(v_o), 64'd0);
    chk("rst_count", 64'(invalid_count_o), 64'd0);
    chk("rst_fields", 64'({x_cord_o, y_cord_o, epa_o, req_id_o}), 64'd0);
    chk("rst_tgo", 64'({xl_tgo_x_o, xl_tgo_y_o}), 64'd0);
    model_reset();
    @(negedge clk_i);
    reset_n_i = 1'b1;
    drive(2'b11, 1, 0);
    #1;
    chk("ptr_restart", 64'(req_ready_o), 64'd1);
    cycle();
    repeat (10) begin drive(2'($urandom_range(0, 3)), 1, 0); cycle(); end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
